// File: rtl/wave_pkg.sv
// Sample type and PWM period constants shared by the waves generator and its output stage.
package wave_pkg;

    localparam int SAMPLE_W   = 8;
    localparam int PWM_PERIOD = 256;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Last counter value of a PWM period; the pop happens on the edge leaving it.
    localparam sample_t PWM_LAST = sample_t'(PWM_PERIOD - 1);

endpackage

// File: rtl/wave_sample_fifo.sv
// Sample FIFO, DEPTH entries; pushed data is visible at o_pop_dat the cycle after the push.
// Backpressure via o_full/o_empty only; a push when full or a pop when empty is ignored.
module wave_sample_fifo
    import wave_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  sample_t          i_push_dat,
    input  logic             i_pop,
    output sample_t          o_pop_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    sample_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_push;
    logic w_pop;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_pop_dat = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/wave_pwm_out.sv
// Sample-to-PWM output stage: one sample per 256-cycle period, pwm_out registered one cycle behind cnt.
// Backpressure: sample_ready drops when the FIFO is full or ena is low; an empty FIFO at a period boundary sets underrun.
module wave_pwm_out
    import wave_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                clear_underrun,
    output logic                pwm_out,
    output logic                underrun,
    output logic [LVL_W-1:0]    fifo_level
);

    sample_t r_cnt;
    sample_t r_duty;
    logic    r_pwm;
    logic    r_underrun;

    sample_t          w_head;
    logic             w_full;
    logic             w_empty;
    logic [LVL_W-1:0] w_level;
    logic             w_boundary;
    logic             w_push;
    logic             w_pop;

    assign w_boundary   = ena && (r_cnt == PWM_LAST);
    assign w_pop        = w_boundary && !w_empty;
    assign sample_ready = ena && !w_full;
    assign w_push       = sample_valid && sample_ready;

    wave_sample_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (sample_in),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (w_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_duty <= '0;
        end else if (ena) begin
            r_cnt <= r_cnt + sample_t'(1);
            if (w_pop) begin
                r_duty <= w_head;
            end
        end
    end

    // Compare against the current cnt so the pulse covers cnt = 1..duty of the next cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else if (!ena) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (r_cnt < r_duty);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else if (w_boundary && w_empty) begin
            r_underrun <= 1'b1;
        end else if (clear_underrun) begin
            r_underrun <= 1'b0;
        end
    end

    assign pwm_out    = r_pwm;
    assign underrun   = r_underrun;
    assign fifo_level = w_level;

endmodule

// File: tb/tb_wave_pwm_out.sv
// Self-checking bench for wave_pwm_out: vector table plus directed corner sequences, PWM windows scored against a queue.
module tb_wave_pwm_out;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk            = 1'b0;
    logic             rst_n          = 1'b0;
    logic             ena            = 1'b0;
    logic [7:0]       sample_in      = '0;
    logic             sample_valid   = 1'b0;
    logic             clear_underrun = 1'b0;
    logic             sample_ready;
    logic             pwm_out;
    logic             underrun;
    logic [LVL_W-1:0] fifo_level;

    int checks   = 0;
    int failures = 0;

    wave_pwm_out #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .clear_underrun (clear_underrun),
        .pwm_out        (pwm_out),
        .underrun       (underrun),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    // Expected high-cycle counts, pushed when a sample is driven, popped at the boundary that consumes it.
    int exp_q[$];

    logic [7:0] m_cnt   = '0;
    int         m_lvl   = 0;
    int         m_hi    = 0;
    logic       m_und   = 1'b0;
    int         acc_cnt = 0;

    wire m_acc = sample_valid && ena && (m_lvl != DEPTH);
    wire m_bnd = ena && (m_cnt == 8'hFF);
    wire m_pop = m_bnd && (m_lvl != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= '0;
            m_lvl <= 0;
            m_hi  <= 0;
            m_und <= 1'b0;
            exp_q.delete();
        end else begin
            if (ena) m_cnt <= m_cnt + 8'd1;
            if (m_acc) acc_cnt <= acc_cnt + 1;
            m_lvl <= m_lvl + int'(m_acc) - int'(m_pop);
            if (m_pop && exp_q.size() > 0) m_hi <= exp_q.pop_front();
            if (m_bnd && m_lvl == 0) m_und <= 1'b1;
            else if (clear_underrun) m_und <= 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input logic [7:0] target);
        int n = 0;
        while (m_cnt != target && n < 600) begin
            tick();
            n++;
        end
        if (m_cnt != target) begin
            checks++;
            failures++;
            $display("FAIL wait_cnt: got %0d, expected %0d at %0t", m_cnt, target, $time);
        end
    endtask

    task automatic push_sample(input logic [7:0] s, input int hi);
        int start = acc_cnt;
        int n = 0;
        exp_q.push_back(hi);
        sample_in    = s;
        sample_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (acc_cnt == start && n < 700);
        sample_valid = 1'b0;
        if (acc_cnt == start) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: got no accept, expected accept of %0h at %0t", s, $time);
        end
    endtask

    // Runs to the next boundary and one cycle past it so the monitor closes the window.
    task automatic finish_window();
        wait_cnt(8'hFF);
        tick();
        tick();
    endtask

    task automatic do_reset();
        sample_valid   = 1'b0;
        clear_underrun = 1'b0;
        ena            = 1'b1;
        rst_n          = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Window = observed cycles cnt 0..255; pwm_out there carries exactly duty highs at cnt 1..duty.
    int         w_hi      = 0;
    int         w_first   = -1;
    int         w_last    = -1;
    int         w_exp     = 0;
    bit         w_started = 1'b0;
    bit         w_dirty   = 1'b1;
    bit         ena_prev  = 1'b0;
    logic [7:0] prev_cnt  = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                w_started = 1'b0;
                w_dirty   = 1'b1;
                ena_prev  = 1'b0;
                prev_cnt  = '0;
            end else begin
                if (prev_cnt == 8'hFF && m_cnt == 8'h00) begin
                    if (w_started && !w_dirty) begin
                        check("win_high_count", w_hi, w_exp);
                        if (w_hi > 0) begin
                            check("win_first_high", w_first, 1);
                            check("win_last_high", w_last, w_hi);
                        end
                    end
                    w_started = 1'b1;
                    w_dirty   = 1'b0;
                    w_hi      = 0;
                    w_first   = -1;
                    w_last    = -1;
                    w_exp     = m_hi;
                end
                if (!ena || !ena_prev) w_dirty = 1'b1;
                if (!ena_prev) check("pwm_forced_low", pwm_out, 0);
                if (pwm_out) begin
                    w_hi++;
                    if (w_first < 0) w_first = m_cnt;
                    w_last = m_cnt;
                end
                check("ready", sample_ready, int'(ena && (m_lvl != DEPTH)));
                check("level", fifo_level, m_lvl);
                check("underrun", underrun, m_und);
                prev_cnt = m_cnt;
                ena_prev = ena;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] smp;
        int         hi;
        int         lvl;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;

        vecs[0] = '{8'h40,  64, 1};
        vecs[1] = '{8'h00,   0, 2};
        vecs[2] = '{8'hFF, 255, 3};
        vecs[3] = '{8'h01,   1, 4};
        vecs[4] = '{8'h80, 128, 4};
        vecs[5] = '{8'hFE, 254, 4};

        // Reset values
        rst_n = 1'b0;
        ena   = 1'b0;
        tick();
        tick();
        check("rst_pwm", pwm_out, 0);
        check("rst_underrun", underrun, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready_ena0", sample_ready, 0);
        ena = 1'b1;
        #1;
        check("rst_ready_ena1", sample_ready, 1);
        tick();
        rst_n = 1'b1;

        // Single sample pushed at cycle 2
        wait_cnt(8'd2);
        push_sample(8'h40, 64);
        check("single_level", fifo_level, 1);
        wait_cnt(8'hFF);
        check("single_prepop_level", fifo_level, 1);
        tick();
        check("single_pop_level", fifo_level, 0);
        check("single_no_underrun", underrun, 0);
        finish_window();

        // Underrun, clear, set-wins-over-clear
        do_reset();
        wait_cnt(8'hFF);
        check("udr_before", underrun, 0);
        tick();
        check("udr_set_255", underrun, 1);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        check("udr_cleared", underrun, 0);
        wait_cnt(8'hFF);
        check("udr_still_clear", underrun, 0);
        tick();
        check("udr_set_511", underrun, 1);
        check("udr_pwm_low", pwm_out, 0);
        wait_cnt(8'hFF);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        check("udr_set_wins", underrun, 1);

        // Push into an empty FIFO on the boundary edge
        do_reset();
        wait_cnt(8'hFF);
        exp_q.push_back(128);
        sample_in    = 8'h80;
        sample_valid = 1'b1;
        check("col_ready", sample_ready, 1);
        tick();
        sample_valid = 1'b0;
        check("col_underrun", underrun, 1);
        check("col_level", fifo_level, 1);
        wait_cnt(8'hFF);
        check("col_wait_level", fifo_level, 1);
        tick();
        check("col_pop_level", fifo_level, 0);
        finish_window();

        // Vector table: burst fill, stall while full, duty extremes
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_sample(vecs[i].smp, vecs[i].hi);
            check($sformatf("vec%0d_level", i), fifo_level, vecs[i].lvl);
        end
        repeat (5) finish_window();
        check("tbl_queue_drained", exp_q.size(), 0);
        check("tbl_final_level", fifo_level, 0);

        // ena dropped mid-period
        do_reset();
        push_sample(8'h80, 128);
        push_sample(8'h20, 32);
        wait_cnt(8'hFF);
        tick();
        wait_cnt(8'd50);
        check("ena_pwm_before", pwm_out, 1);
        ena = 1'b0;
        repeat (10) tick();
        check("ena_pwm_frozen", pwm_out, 0);
        check("ena_ready_low", sample_ready, 0);
        check("ena_level_held", fifo_level, 1);
        ena = 1'b1;
        n = 0;
        while (fifo_level == 1 && n < 400) begin
            tick();
            n++;
        end
        check("ena_resume_len", n, 206);
        finish_window();

        // Async reset mid-period with three samples buffered
        do_reset();
        for (int i = 0; i < 4; i++) push_sample(8'hFF, 255);
        check("ar_full", fifo_level, 4);
        wait_cnt(8'hFF);
        tick();
        wait_cnt(8'd100);
        check("ar_pwm_high", pwm_out, 1);
        check("ar_level3", fifo_level, 3);
        rst_n = 1'b0;
        #1;
        check("ar_pwm", pwm_out, 0);
        check("ar_underrun", underrun, 0);
        check("ar_level", fifo_level, 0);
        check("ar_ready", sample_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_post_level", fifo_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
